// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect,
// and the decode-side valid/ready handshake.
interface fetch_queue_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_ready;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_valid, imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_valid, imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one-cycle-latency word
// reads, and buffers returned {pc, instr} pairs in a small FIFO for decode.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]  pc_reg;
  logic [ADDR_W-1:0]  inflight_pc_reg;
  logic               inflight_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [CNT_W:0]     occupancy;
  logic [ADDR_W-1:0]  redirect_base;
  logic               issue;
  logic               push;
  logic               pop;

  // A request is only issued when a slot is guaranteed for its response;
  // a pop in the same cycle is deliberately not credited.
  assign occupancy     = {1'b0, count_reg} + (CNT_W + 1)'(inflight_reg);
  assign issue         = !reset && !bus.redirect && (occupancy < (CNT_W + 1)'(DEPTH));
  assign push          = bus.imem_valid && !bus.redirect;
  assign pop           = bus.out_valid && bus.out_ready && !bus.redirect;
  assign redirect_base = bus.redirect_pc & ~ADDR_W'(3);

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_reg;
  assign bus.out_valid = (count_reg != '0);
  assign bus.out_instr = instr_mem[rd_ptr_reg];
  assign bus.out_pc    = pc_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg          <= '0;
      inflight_pc_reg <= '0;
      inflight_reg    <= 1'b0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else if (bus.redirect) begin
      pc_reg       <= redirect_base;
      inflight_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      if (issue) begin
        pc_reg          <= pc_reg + ADDR_W'(4);
        inflight_reg    <= 1'b1;
        inflight_pc_reg <= pc_reg;
      end else begin
        inflight_reg <= 1'b0;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset; entries are only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= inflight_pc_reg;
      instr_mem[wr_ptr_reg] <= bus.imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) assert (count_reg != CNT_W'(DEPTH));
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a one-cycle-latency memory returns pc>>2,
// and each scenario task checks request/response timing and ordering.
module tb_fetch_queue;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fetch_queue_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

  fetch_queue #(.DEPTH(4), .ADDR_W(64), .INSTR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: fixed one-cycle latency, instruction word = address>>2.
  always @(posedge clk) begin
    bus.imem_valid <= bus.imem_req;
    bus.imem_rdata <= bus.imem_addr[33:2];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Leaves the bench just after the negedge of post-reset cycle 0.
  task automatic start_run(input logic ready);
    @(negedge clk);
    reset = 1'b1; bus.redirect = 1'b0; bus.out_ready = ready;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 64'h300; bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req_comb: got %0b want 0", bus.imem_req); end
    @(negedge clk); #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", bus.imem_addr); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
    @(negedge clk);
    reset = 1'b0; bus.redirect = 1'b0;
    #1;
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_c0_req: got req=%0b addr=%0h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_c0_valid: got %0b want 0", bus.out_valid); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 64'h4) begin n_fail++; $display("FAIL reset_c1: got valid=%0b addr=%0h want valid=0 addr=4", bus.out_valid, bus.imem_addr); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0 || bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_c2: got valid=%0b pc=%0h instr=%0h want valid=1 pc=0 instr=0", bus.out_valid, bus.out_pc, bus.out_instr); end
    $display("test_reset done");
  endtask

  task automatic test_free_run();
    logic [63:0] exp_pc;
    start_run(1'b1);
    for (int c = 0; c < 12; c++) begin
      if (c != 0) begin @(negedge clk); #1; end
      n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'(4 * c)) begin n_fail++; $display("FAIL free_req c%0d: got req=%0b addr=%0h want req=1 addr=%0h", c, bus.imem_req, bus.imem_addr, 4 * c); end
      n_checks++; if (bus.out_valid !== (c >= 2)) begin n_fail++; $display("FAIL free_valid c%0d: got %0b want %0b", c, bus.out_valid, c >= 2); end
      if (c >= 2) begin
        exp_pc = 64'(4 * (c - 2));
        n_checks++; if (bus.out_pc !== exp_pc || bus.out_instr !== exp_pc[33:2]) begin n_fail++; $display("FAIL free_data c%0d: got pc=%0h instr=%0h want pc=%0h instr=%0h", c, bus.out_pc, bus.out_instr, exp_pc, exp_pc[33:2]); end
      end
      $display("free_run cycle %0d pc=%0h instr=%0h", c, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_pc;
    start_run(1'b0);
    for (int c = 0; c < 7; c++) begin
      if (c != 0) begin @(negedge clk); #1; end
      n_checks++; if (bus.imem_req !== (c < 4)) begin n_fail++; $display("FAIL bp_req c%0d: got %0b want %0b", c, bus.imem_req, c < 4); end
      if (c < 4) begin
        n_checks++; if (bus.imem_addr !== 64'(4 * c)) begin n_fail++; $display("FAIL bp_addr c%0d: got %0h want %0h", c, bus.imem_addr, 4 * c); end
      end
    end
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) begin n_fail++; $display("FAIL bp_full_head: got valid=%0b pc=%0h want valid=1 pc=0", bus.out_valid, bus.out_pc); end
    exp_pc = 64'h0;
    for (int c = 7; c < 19; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      if (c == 7) begin
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_no_credit: got %0b want 0", bus.imem_req); end
      end
      if (c == 8) begin
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h10) begin n_fail++; $display("FAIL bp_resume: got req=%0b addr=%0h want req=1 addr=10", bus.imem_req, bus.imem_addr); end
      end
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_instr !== exp_pc[33:2]) begin n_fail++; $display("FAIL bp_drain c%0d: got valid=%0b pc=%0h instr=%0h want valid=1 pc=%0h instr=%0h", c, bus.out_valid, bus.out_pc, bus.out_instr, exp_pc, exp_pc[33:2]); end
      $display("backpressure drain cycle %0d pc=%0h", c, bus.out_pc);
      exp_pc = exp_pc + 64'h4;
    end
  endtask

  task automatic test_pulse();
    start_run(1'b0);
    for (int c = 1; c < 6; c++) begin @(negedge clk); #1; end
    @(negedge clk); bus.out_ready = 1'b1; #1;
    n_checks++; if (bus.imem_req !== 1'b0 || bus.out_pc !== 64'h0) begin n_fail++; $display("FAIL pulse_c6: got req=%0b pc=%0h want req=0 pc=0", bus.imem_req, bus.out_pc); end
    @(negedge clk); bus.out_ready = 1'b0; #1;
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h10 || bus.out_pc !== 64'h4) begin n_fail++; $display("FAIL pulse_c7: got req=%0b addr=%0h pc=%0h want req=1 addr=10 pc=4", bus.imem_req, bus.imem_addr, bus.out_pc); end
    @(negedge clk); #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL pulse_c8_req: got %0b want 0", bus.imem_req); end
    @(negedge clk); #1;
    n_checks++; if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== 64'h4) begin n_fail++; $display("FAIL pulse_c9_full: got req=%0b valid=%0b pc=%0h want req=0 valid=1 pc=4", bus.imem_req, bus.out_valid, bus.out_pc); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); bus.out_ready = 1'b1; #1;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(4 + 4 * k)) begin n_fail++; $display("FAIL pulse_order k%0d: got valid=%0b pc=%0h want valid=1 pc=%0h", k, bus.out_valid, bus.out_pc, 4 + 4 * k); end
      $display("pulse drain %0d pc=%0h", k, bus.out_pc);
    end
  endtask

  task automatic test_redirect();
    start_run(1'b0);
    for (int c = 1; c < 4; c++) begin @(negedge clk); #1; end
    @(negedge clk);
    bus.redirect = 1'b1; bus.redirect_pc = 64'h100; bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_t: got req=%0b valid=%0b want req=0 valid=1", bus.imem_req, bus.out_valid); end
    @(negedge clk); bus.redirect = 1'b0; #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h100) begin n_fail++; $display("FAIL redir_t1: got valid=%0b req=%0b addr=%0h want valid=0 req=1 addr=100", bus.out_valid, bus.imem_req, bus.imem_addr); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 64'h104) begin n_fail++; $display("FAIL redir_t2: got valid=%0b addr=%0h want valid=0 addr=104", bus.out_valid, bus.imem_addr); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h100 || bus.out_instr !== 32'h40) begin n_fail++; $display("FAIL redir_t3: got valid=%0b pc=%0h instr=%0h want valid=1 pc=100 instr=40", bus.out_valid, bus.out_pc, bus.out_instr); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h104 || bus.out_instr !== 32'h41) begin n_fail++; $display("FAIL redir_t4: got valid=%0b pc=%0h instr=%0h want valid=1 pc=104 instr=41", bus.out_valid, bus.out_pc, bus.out_instr); end
    $display("redirect to 100 checked");
    @(negedge clk);
    bus.redirect = 1'b1; bus.redirect_pc = 64'h203;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL redir2_t: got req=%0b want 0", bus.imem_req); end
    @(negedge clk); bus.redirect = 1'b0; #1;
    n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h200 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir2_align: got req=%0b addr=%0h valid=%0b want req=1 addr=200 valid=0", bus.imem_req, bus.imem_addr, bus.out_valid); end
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h200 || bus.out_instr !== 32'h80) begin n_fail++; $display("FAIL redir2_t3: got valid=%0b pc=%0h instr=%0h want valid=1 pc=200 instr=80", bus.out_valid, bus.out_pc, bus.out_instr); end
    $display("redirect to 203 checked");
  endtask

  task automatic test_reset_midstream();
    start_run(1'b0);
    for (int c = 1; c < 6; c++) begin @(negedge clk); #1; end
    @(negedge clk); reset = 1'b1; #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_reset_req: got %0b want 0", bus.imem_req); end
    @(negedge clk); reset = 1'b0; bus.out_ready = 1'b1; #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin n_fail++; $display("FAIL mid_c0: got valid=%0b req=%0b addr=%0h want valid=0 req=1 addr=0", bus.out_valid, bus.imem_req, bus.imem_addr); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 64'h4) begin n_fail++; $display("FAIL mid_c1: got valid=%0b addr=%0h want valid=0 addr=4", bus.out_valid, bus.imem_addr); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0 || bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL mid_c2: got valid=%0b pc=%0h instr=%0h want valid=1 pc=0 instr=0", bus.out_valid, bus.out_pc, bus.out_instr); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h4) begin n_fail++; $display("FAIL mid_c3: got valid=%0b pc=%0h want valid=1 pc=4", bus.out_valid, bus.out_pc); end
    $display("mid-stream reset checked");
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 64'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_free_run();
    test_backpressure();
    test_pulse();
    test_redirect();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
